// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
//
// N-master to 1-slave Wishbone classic arbiter. A master wins the bus on the
// edge after it raises cyc and keeps it until it drops cyc; there is no
// preemption. Winners are chosen by fixed priority (master 0 highest) or
// round-robin. A per-transfer watchdog terminates a hung slave with err.
//
// Handshake: a transfer is offered while wb_cyc_o & wb_stb_o are high and
// completes in the cycle the slave answers with wb_ack_i or wb_err_i; the
// answer is routed only to the granted master (m_ack_o / m_err_o).
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i per-master cycle, strobe, write enable
//   m_adr_i/m_dat_i/m_sel_i packed per-master address, write data, selects
//                          (master k at [k*W +: W])
//   m_dat_o                slave read data, broadcast to every master
//   m_ack_o/m_err_o        per-master responses
//   wb_*_o / wb_*_i        slave-side Wishbone port
//   grant_o                one-hot current owner (zero when idle)
//   busy_o                 high while a grant is active
// ---------------------------------------------------------------------------
module wb_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              wb_cyc_o,
    output logic                              wb_stb_o,
    output logic                              wb_we_o,
    output logic [ADDR_WIDTH-1:0]             wb_adr_o,
    output logic [DATA_WIDTH-1:0]             wb_dat_o,
    output logic [SEL_WIDTH-1:0]              wb_sel_o,
    input  logic [DATA_WIDTH-1:0]             wb_dat_i,
    input  logic                              wb_ack_i,
    input  logic                              wb_err_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic            WD_EN  = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       rr_ptr;
    logic [WD_W-1:0]        wd_cnt;

    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   busy;
    logic                   sel_cyc;
    logic                   raw_stb;
    logic                   wd_err;

    // Winner search. In round-robin mode the scan starts at rr_ptr and wraps;
    // otherwise it starts at master 0, giving lowest-index priority.
    always_comb begin
        int cand;
        cand      = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (RR_MODE != 0) ? ((int'(rr_ptr) + i) % NUM_MASTERS) : i;
            if (!win_found && m_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Index of the current owner; only meaningful while busy.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) gnt_idx = IDX_W'(i);
        end
    end

    assign busy    = (state == ST_GRANT);
    assign sel_cyc = busy & m_cyc_i[gnt_idx];
    assign raw_stb = sel_cyc & m_stb_i[gnt_idx];
    // Counter sits at TIMEOUT after TIMEOUT unanswered strobes; the next
    // strobe cycle is turned into an err instead of reaching the slave.
    assign wd_err  = WD_EN & busy & (wd_cnt == WD_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            wd_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (win_found) begin
                        state <= ST_GRANT;
                        grant <= ONE << win_idx;
                    end
                end
                ST_GRANT: begin
                    if (!m_cyc_i[gnt_idx]) begin
                        // Release: the idle cycle that follows is the
                        // mandatory turnaround before the next grant.
                        state  <= ST_IDLE;
                        grant  <= '0;
                        rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                        wd_cnt <= '0;
                    end else if (wd_err || wb_ack_i || wb_err_i) begin
                        wd_cnt <= '0;
                    end else if (WD_EN && raw_stb) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Slave-side request mux; everything reads as zero while idle.
    assign wb_cyc_o = sel_cyc;
    assign wb_stb_o = raw_stb & ~wd_err;
    assign wb_we_o  = busy & m_we_i[gnt_idx];
    assign wb_adr_o = busy ? m_adr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign wb_dat_o = busy ? m_dat_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign wb_sel_o = busy ? m_sel_i[gnt_idx*SEL_WIDTH +: SEL_WIDTH] : '0;

    // Responses follow the grant register, so a non-owner never sees them.
    assign m_dat_o  = wb_dat_i;
    assign m_ack_o  = grant & {NUM_MASTERS{wb_ack_i}};
    assign m_err_o  = grant & {NUM_MASTERS{wb_err_i | wd_err}};

    assign grant_o  = grant;
    assign busy_o   = busy;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_bus_arbiter
//
// Two arbiters with three masters each: instance 0 is round-robin with a
// 4-cycle watchdog, instance 1 is fixed priority with the watchdog disabled.
// Masters and slave are driven from tasks; expected transfer order comes from
// a transaction-level model of the grant policy.
// ---------------------------------------------------------------------------
module tb_wb_bus_arbiter;

  localparam int NM   = 3;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int SW   = 2;
  localparam int TO_A = 4;
  localparam int EW   = 2 + 1 + AW + DW + SW;
  localparam int MAX_CYC = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- per-instance signals (index 0 = RR, 1 = fixed) -------
  logic [NM-1:0]    m_cyc [2];
  logic [NM-1:0]    m_stb [2];
  logic [NM-1:0]    m_we  [2];
  logic [NM*AW-1:0] m_adr [2];
  logic [NM*DW-1:0] m_wdat[2];
  logic [NM*SW-1:0] m_sel [2];
  logic [DW-1:0]    m_rdat[2];
  logic [NM-1:0]    m_ack [2];
  logic [NM-1:0]    m_err [2];
  logic             s_cyc [2];
  logic             s_stb [2];
  logic             s_we  [2];
  logic [AW-1:0]    s_adr [2];
  logic [DW-1:0]    s_wdat[2];
  logic [SW-1:0]    s_sel [2];
  logic [DW-1:0]    s_rdat[2];
  logic             s_ack [2];
  logic             s_err [2];
  logic [NM-1:0]    gnt   [2];
  logic             busy  [2];

  wb_bus_arbiter #(
    .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW),
    .RR_MODE(1), .TIMEOUT(TO_A)
  ) u_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cyc_i(m_cyc[0]), .m_stb_i(m_stb[0]), .m_we_i(m_we[0]),
    .m_adr_i(m_adr[0]), .m_dat_i(m_wdat[0]), .m_sel_i(m_sel[0]),
    .m_dat_o(m_rdat[0]), .m_ack_o(m_ack[0]), .m_err_o(m_err[0]),
    .wb_cyc_o(s_cyc[0]), .wb_stb_o(s_stb[0]), .wb_we_o(s_we[0]),
    .wb_adr_o(s_adr[0]), .wb_dat_o(s_wdat[0]), .wb_sel_o(s_sel[0]),
    .wb_dat_i(s_rdat[0]), .wb_ack_i(s_ack[0]), .wb_err_i(s_err[0]),
    .grant_o(gnt[0]), .busy_o(busy[0])
  );

  wb_bus_arbiter #(
    .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW),
    .RR_MODE(0), .TIMEOUT(0)
  ) u_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cyc_i(m_cyc[1]), .m_stb_i(m_stb[1]), .m_we_i(m_we[1]),
    .m_adr_i(m_adr[1]), .m_dat_i(m_wdat[1]), .m_sel_i(m_sel[1]),
    .m_dat_o(m_rdat[1]), .m_ack_o(m_ack[1]), .m_err_o(m_err[1]),
    .wb_cyc_o(s_cyc[1]), .wb_stb_o(s_stb[1]), .wb_we_o(s_we[1]),
    .wb_adr_o(s_adr[1]), .wb_dat_o(s_wdat[1]), .wb_sel_o(s_sel[1]),
    .wb_dat_i(s_rdat[1]), .wb_ack_i(s_ack[1]), .wb_err_i(s_err[1]),
    .grant_o(gnt[1]), .busy_o(busy[1])
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  bit   wd_test[2];
  int   ptr_m[2];
  logic [NM-1:0] mon_prev[2];

  // Current round description.
  bit            act  [NM];
  int            dly  [NM];
  int            nb   [NM];
  logic          t_we [NM][4];
  logic [AW-1:0] t_adr[NM][4];
  logic [DW-1:0] t_dat[NM][4];
  logic [SW-1:0] t_sel[NM][4];
  int            fixed_ack = -1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [1:0] oh2i(input logic [NM-1:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < NM; k++) if (g[k]) r = 2'(k);
    return r;
  endfunction

  // Policy model: first requester in the set, scanning from p (RR) or 0.
  function automatic int pick(input bit [NM-1:0] s, input bit rr, input int p);
    int c;
    for (int i = 0; i < NM; i++) begin
      c = rr ? (p + i) % NM : i;
      if (s[c]) return c;
    end
    return -1;
  endfunction

  function automatic int next_dly();
    return (fixed_ack >= 0) ? fixed_ack : int'($urandom_range(0, 3));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_master(input int inst, input int j, input bit on, input int b);
    int bb;
    bb = on ? b : 0;
    m_cyc[inst][j] = on;
    m_stb[inst][j] = on;
    m_we[inst][j]  = on ? t_we[j][bb] : 1'b0;
    m_adr[inst][j*AW +: AW]  = t_adr[j][bb];
    m_wdat[inst][j*DW +: DW] = t_dat[j][bb];
    m_sel[inst][j*SW +: SW]  = t_sel[j][bb];
  endtask

  task automatic fill_data();
    for (int j = 0; j < NM; j++)
      for (int b = 0; b < 4; b++) begin
        t_we[j][b]  = 1'($urandom_range(0, 1));
        t_adr[j][b] = $urandom;
        t_dat[j][b] = DW'($urandom);
        t_sel[j][b] = SW'($urandom_range(0, 3));
      end
  endtask

  task automatic clear_round();
    for (int j = 0; j < NM; j++) begin
      act[j] = 1'b0; dly[j] = 0; nb[j] = 1;
    end
    fill_data();
    fixed_ack = -1;
  endtask

  task automatic rand_round();
    int mask;
    mask = $urandom_range(1, 7);
    for (int j = 0; j < NM; j++) begin
      act[j] = mask[j];
      dly[j] = $urandom_range(0, 2);
      nb[j]  = $urandom_range(1, 4);
    end
    fill_data();
    fixed_ack = -1;
  endtask

  task automatic push_exp(input int inst, input logic [EW-1:0] e);
    if (inst == 0) exp_q0.push_back(e);
    else           exp_q1.push_back(e);
  endtask

  // Runs one round: every active master performs nb[j] beats starting dly[j]
  // cycles in; the slave answers each strobe after a (random) wait.
  task automatic run_round(input int inst);
    bit rr;
    bit [NM-1:0] cand, rem;
    int k, dmin, cyc, wcnt, cur_dly, qsz;
    bit first_seen, finished;
    int beat[NM];
    bit up[NM], done[NM], pack[NM];

    rr = (inst == 0);
    // Expected service order. Only the earliest requesters compete for the
    // first grant; every later requester is already waiting by the time that
    // first owner releases the bus.
    dmin = 99;
    for (int j = 0; j < NM; j++) if (act[j] && dly[j] < dmin) dmin = dly[j];
    cand = '0; rem = '0;
    for (int j = 0; j < NM; j++) begin
      rem[j]  = act[j];
      cand[j] = act[j] && (dly[j] == dmin);
    end
    k = pick(cand, rr, ptr_m[inst]);
    while (k >= 0) begin
      rem[k] = 1'b0;
      for (int b = 0; b < nb[k]; b++)
        push_exp(inst, {2'(k), t_we[k][b], t_adr[k][b], t_dat[k][b], t_sel[k][b]});
      ptr_m[inst] = (k + 1) % NM;
      k = pick(rem, rr, ptr_m[inst]);
    end

    for (int j = 0; j < NM; j++) begin
      beat[j] = 0; up[j] = 0; done[j] = 0; pack[j] = 0;
    end
    cur_dly = next_dly();
    wcnt = 0;
    first_seen = 0;
    for (cyc = 0; cyc < MAX_CYC; cyc++) begin
      @(posedge clk); #1;
      s_ack[inst] = 1'b0;
      for (int j = 0; j < NM; j++) begin
        if (act[j] && !done[j]) begin
          if (up[j] && pack[j]) begin
            beat[j]++;
            if (beat[j] == nb[j]) begin done[j] = 1; up[j] = 0; end
          end
          if (!up[j] && !done[j] && cyc >= dly[j]) begin up[j] = 1; beat[j] = 0; end
          drive_master(inst, j, up[j], beat[j]);
        end
      end
      #1;
      if (s_cyc[inst] && !first_seen) begin
        first_seen = 1;
        chk("grant_latency", 64'(cyc), 64'(dmin + 1));
      end
      if (s_stb[inst]) begin
        if (wcnt >= cur_dly) begin
          s_ack[inst]  = 1'b1;
          s_rdat[inst] = DW'($urandom);
          wcnt = 0;
          cur_dly = next_dly();
        end else begin
          wcnt++;
        end
      end
      #1;
      for (int j = 0; j < NM; j++) pack[j] = m_ack[inst][j];
      finished = 1;
      for (int j = 0; j < NM; j++) if (act[j] && !done[j]) finished = 0;
      if (finished && !busy[inst]) break;
    end
    if (cyc >= MAX_CYC) begin
      n_checks++; n_fail++;
      $display("FAIL round_timeout: inst %0d did not finish in %0d cycles", inst, MAX_CYC);
    end
    s_ack[inst] = 1'b0;
    for (int j = 0; j < NM; j++) drive_master(inst, j, 1'b0, 0);
    qsz = (inst == 0) ? exp_q0.size() : exp_q1.size();
    chk("queue_drained", 64'(qsz), 64'd0);
    if (inst == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got, want;
    if (!rst_n) begin
      mon_prev[0] = '0;
      mon_prev[1] = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk("onehot_busy", {60'd0, gnt[i] & (gnt[i] - 1'b1), busy[i]},
            {63'd0, (gnt[i] != '0)});
        if (gnt[i] != '0 && gnt[i] != mon_prev[i])
          chk("turnaround_idle", 64'(mon_prev[i]), 64'd0);
        chk("ack_route", 64'(m_ack[i]), 64'(s_ack[i] ? gnt[i] : 3'b000));
        if (!wd_test[i])
          chk("err_route", 64'(m_err[i]), 64'(s_err[i] ? gnt[i] : 3'b000));
        if (s_ack[i] && gnt[i] != '0) begin
          got = {oh2i(gnt[i]), s_we[i], s_adr[i], s_wdat[i], s_sel[i]};
          if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            n_checks++; n_fail++;
            $display("FAIL beat: inst %0d got %h with nothing expected", i, got);
          end else begin
            want = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("beat", 64'(got), 64'(want));
          end
          chk("rdata_pass", 64'(m_rdat[i]), 64'(s_rdat[i]));
        end
        mon_prev[i] = gnt[i];
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic watchdog_test();
    clear_round();
    wd_test[0] = 1;
    @(posedge clk); #1;
    drive_master(0, 0, 1'b1, 0);
    for (int n = 1; n <= TO_A + 1; n++) begin
      @(posedge clk); #2;
      chk("wd_err", 64'(m_err[0]), (n == TO_A + 1) ? 64'd1 : 64'd0);
      chk("wd_stb", 64'(s_stb[0]), (n == TO_A + 1) ? 64'd0 : 64'd1);
    end
    @(posedge clk); #1;
    drive_master(0, 0, 1'b0, 0);
    @(posedge clk); @(posedge clk); #2;
    chk("wd_idle", 64'(busy[0]), 64'd0);
    wd_test[0] = 0;
    ptr_m[0] = 1;
  endtask

  task automatic async_reset_test();
    clear_round();
    t_we[2][0]  = 1'b1;
    t_adr[2][0] = 32'hA5A5_0004;
    t_sel[2][0] = 2'b11;
    @(posedge clk); #1;
    drive_master(0, 2, 1'b1, 0);
    @(posedge clk); #2;
    chk("pre_rst_grant", 64'(gnt[0]), 64'd4);
    chk("pre_rst_stb", 64'(s_stb[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wb_out", 64'({s_cyc[0], s_stb[0], s_we[0], s_adr[0], s_sel[0]}), 64'd0);
    chk("rst_grant_busy", 64'({gnt[0], busy[0]}), 64'd0);
    chk("rst_resp", 64'({m_ack[0], m_err[0]}), 64'd0);
    drive_master(0, 2, 1'b0, 0);
    #1;
    rst_n = 1'b1;
    ptr_m[0] = 0;
    ptr_m[1] = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = '0; m_stb[i] = '0; m_we[i] = '0;
      m_adr[i] = '0; m_wdat[i] = '0; m_sel[i] = '0;
      s_ack[i] = 1'b0; s_err[i] = 1'b0;
      wd_test[i] = 0; ptr_m[i] = 0; mon_prev[i] = '0;
    end
    s_rdat[0] = 16'hBEEF;
    s_rdat[1] = 16'h1234;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset_outputs",
          64'({gnt[i], busy[i], s_cyc[i], s_stb[i], s_we[i], s_adr[i], s_wdat[i],
               s_sel[i], m_ack[i], m_err[i]}), 64'd0);
      chk("reset_rdata_pass", 64'(m_rdat[i]), 64'(s_rdat[i]));
    end
    #10 rst_n = 1'b1;

    // Single master read at 0x1000, slave waits 3 cycles.
    clear_round();
    act[1] = 1; t_we[1][0] = 1'b0; t_adr[1][0] = 32'h0000_1000; fixed_ack = 3;
    run_round(1);

    // Simultaneous requests under fixed priority.
    clear_round();
    act[0] = 1; act[1] = 1;
    run_round(1);

    // Master 1 bursts 4 beats while master 0 arrives later: no preemption.
    clear_round();
    act[0] = 1; act[1] = 1; dly[0] = 2; nb[1] = 4;
    run_round(1);

    // Slow slave with the watchdog disabled must never see err.
    clear_round();
    act[0] = 1; fixed_ack = 12;
    run_round(1);

    // Round-robin with all three requesting single beats.
    clear_round();
    for (int j = 0; j < NM; j++) act[j] = 1;
    run_round(0);

    watchdog_test();
    async_reset_test();

    // After reset the RR pointer must be back at master 0.
    clear_round();
    for (int j = 0; j < NM; j++) act[j] = 1;
    run_round(0);

    for (int r = 0; r < 12; r++) begin
      rand_round();
      run_round(0);
      rand_round();
      run_round(1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
